// File: rtl/fetch_dispatch_unit_if.sv
// rtl/fetch_dispatch_unit_if.sv - ROM fetch bus and decoder dispatch handshake
// master is the fetch/dispatch side, slave is the ROM plus decoder side.
interface fetch_dispatch_unit_if #(
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int ROM_DATA_WIDTH = 8,
    parameter int INSTR_WIDTH    = 16
);
    logic [ROM_ADDR_WIDTH-1:0] rom_address;
    logic [ROM_DATA_WIDTH-1:0] data_from_rom;
    logic                      ready_from_decoder;
    logic                      start_for_decoder;
    logic [INSTR_WIDTH-1:0]    data_for_decoder;

    modport master (
        output rom_address,
        input  data_from_rom,
        input  ready_from_decoder,
        output start_for_decoder,
        output data_for_decoder
    );

    modport slave (
        input  rom_address,
        output data_from_rom,
        output ready_from_decoder,
        input  start_for_decoder,
        input  data_for_decoder
    );
endinterface

// File: rtl/fetch_dispatch_unit.sv
// rtl/fetch_dispatch_unit.sv - ROM fetch, instruction assembly, FIFO and decoder dispatch
// Optional FETCH_STATS_EN adds saturating issue_count / stall_count outputs.
module fetch_dispatch_unit #(
    parameter int ROM_ADDR_WIDTH = 8,
    parameter int ROM_DATA_WIDTH = 8,
    parameter int INSTR_WIDTH    = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int PROG_LENGTH    = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    fetch_dispatch_unit_if.master        bus,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]                  issue_count,
    output logic [15:0]                  stall_count
`endif
);
    localparam int BEATS  = INSTR_WIDTH / ROM_DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR = ROM_ADDR_WIDTH'(PROG_LENGTH - 1);
    localparam logic [LVL_W-1:0]          FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    typedef enum logic {DISP_IDLE, DISP_HOLD} disp_t;

    state_t                  state;
    disp_t                   disp_state;
    logic [INSTR_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [INSTR_WIDTH-1:0]  assembly;

    logic                    run_ok;
    logic                    accept;
    logic                    last_beat;
    logic                    push;
    logic                    pop;
    logic [INSTR_WIDTH-1:0]  asm_shift;
    logic [INSTR_WIDTH-1:0]  push_word;

    always_comb begin
        run_ok    = run && (state == IDLE || state == DONE);
        accept    = (state == FETCH) && (fifo_level < FULL_LVL);
        last_beat = (bus.rom_address == LAST_ADDR);
        push      = accept && (last_beat || beat_cnt == LAST_BEAT);
        pop       = (disp_state == DISP_IDLE) && (fifo_level != '0) && bus.ready_from_decoder;
        asm_shift = (assembly << ROM_DATA_WIDTH) | INSTR_WIDTH'(bus.data_from_rom);
        // A short final word is left-aligned so its missing low beats read as zero.
        push_word = asm_shift;
        for (int i = 0; i < BEATS - 1; i++) begin
            if (int'(beat_cnt) + i < BEATS - 1) begin
                push_word = push_word << ROM_DATA_WIDTH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            disp_state            <= DISP_IDLE;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_level            <= '0;
            beat_cnt              <= '0;
            assembly              <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            bus.rom_address       <= '0;
            bus.start_for_decoder <= 1'b0;
            bus.data_for_decoder  <= '0;
        end else begin
            bus.start_for_decoder <= pop;
            disp_state            <= pop ? DISP_HOLD : DISP_IDLE;
            if (pop) begin
                bus.data_for_decoder <= fifo_mem[rd_ptr];
                rd_ptr               <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE, DONE: begin
                    if (run_ok) begin
                        bus.rom_address <= '0;
                        beat_cnt        <= '0;
                        assembly        <= '0;
                        state           <= FETCH;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        if (push) begin
                            assembly <= '0;
                            beat_cnt <= '0;
                        end else begin
                            assembly <= asm_shift;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (last_beat) begin
                            state <= DRAIN;
                        end else begin
                            bus.rom_address <= bus.rom_address + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_level == '0 && disp_state == DISP_IDLE && !pop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || run_ok) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && issue_count != 16'hFFFF) begin
                issue_count <= issue_count + 16'd1;
            end
            if (state == FETCH && !accept && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/fetch_dispatch_unit.md
Name: fetch_dispatch_unit

Overview:
- Parametrised successor to the ROM-to-decoder state machine.
- Streams a program out of a combinational ROM, ROM_DATA_WIDTH bits per beat.
- Assembles beats into INSTR_WIDTH-bit instructions and buffers them in a FIFO_DEPTH-entry FIFO.
- Dispatches them one at a time to the decoder over the start/ready handshake, decoupling fetch from decode latency.

Parameters:
- ROM_ADDR_WIDTH, 8, ROM address width.
- ROM_DATA_WIDTH, 8, ROM data width (one beat).
- INSTR_WIDTH, 16, instruction width; integer multiple of ROM_DATA_WIDTH; BEATS = INSTR_WIDTH/ROM_DATA_WIDTH.
- FIFO_DEPTH, 4, instruction FIFO entries; power of 2, at least 2.
- PROG_LENGTH, 256, ROM beats fetched per run; 1..2^ROM_ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start-of-program pulse; honoured only in IDLE or DONE.
- rom_address  out  ROM_ADDR_WIDTH  registered ROM address.
- data_from_rom  in  ROM_DATA_WIDTH  ROM data, combinational from rom_address, same cycle.
- ready_from_decoder  in  1  decoder idle and able to accept an instruction.
- start_for_decoder  out  1  one-cycle issue strobe.
- data_for_decoder  out  INSTR_WIDTH  issued instruction; registered, held until next issue.
- busy  out  1  high in FETCH or DRAIN.
- done  out  1  high in DONE.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, beat counter 0, assembly register 0, dispatcher IDLE.
- Control FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE/DONE + run: rom_address<=0, beat counter<=0, assembly register cleared, go FETCH.
  - run is ignored while busy.
- FETCH, beat accept:
  - A beat is accepted in a cycle where fifo_level (pre-pop value) < FIFO_DEPTH.
  - On accept: data_from_rom enters the assembly register and rom_address increments.
  - Byte order is big-endian: the first beat becomes the MS beat of the instruction.
  - If fifo_level == FIFO_DEPTH: fetch stalls; rom_address and the partial word hold.
- Push:
  - On the cycle the BEATS-th beat is accepted, the word {assembly, data_from_rom} is pushed the same edge.
  - The beat counter wraps to 0.
- End of program:
  - When beat PROG_LENGTH-1 is accepted, go DRAIN. rom_address holds at PROG_LENGTH-1; it never wraps within a run.
  - If PROG_LENGTH is not a multiple of BEATS, the final partial word is pushed on that edge, zero-padded in its missing low beats.
- DRAIN to DONE: when FIFO is empty and the dispatcher is in DISP_IDLE with no issue this cycle.
- Dispatcher states: DISP_IDLE, DISP_HOLD.
  - DISP_IDLE, FIFO non-empty and ready_from_decoder=1: pop head into data_for_decoder, start_for_decoder=1 for that cycle, go DISP_HOLD.
  - DISP_HOLD: start_for_decoder=0 for exactly one cycle, then DISP_IDLE.
  - Minimum issue spacing is 2 cycles.
  - Decoder contract: ready_from_decoder drops within one cycle of start.
- Latency:
  - First issue occurs at the earliest BEATS+1 cycles after run, given decoder ready.
  - Word pushed on edge N can issue on edge N+1.
- Simultaneous push and pop: fifo_level unchanged; pointers both advance modulo FIFO_DEPTH.
- Pop on empty never happens, since issue is gated by non-empty.
- Push on full never happens, since accept is gated.
- Reset mid-run: reset wins over all events. FIFO contents are discarded, a partial word is lost, an in-flight start pulse is cut, and the block returns to IDLE.
- run coincident with reset: ignored.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds two outputs, both cleared by reset and by an accepted run; both saturate at 16'hFFFF.
  - issue_count out 16: increments per start_for_decoder.
  - stall_count out 16: increments per FETCH cycle with fetch blocked by a full FIFO.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Basic run, defaults, PROG_LENGTH=8, ROM data = addr^8'hA5, decoder ready tied 1 -> four issues: 16'hA5A4, 16'hA7A6, 16'hA1A0, 16'hA3A2. Issues spaced 2 cycles apart; done rises; rom_address holds 7.
- Backpressure, ready held 0 for 20 cycles after run -> fifo_level reaches 4 and rom_address stalls at 8. Releasing ready drains the words in order with no loss or duplication. With FETCH_STATS_EN, stall_count matches the number of blocked cycles.
- Partial word, INSTR_WIDTH=24, PROG_LENGTH=4 -> issues {A5,A4,A7} then {A6,00,00}.
- Reset mid-run asserted with fifo_level=3 and start_for_decoder high -> next cycle all outputs 0, state IDLE. A new run restarts from rom_address 0.
- run during FETCH ignored; run in DONE restarts -> identical issue sequence. With FETCH_STATS_EN, issue_count clears to 0 on restart.
- Slow decoder, ready low for 3 cycles after each start -> no issue while ready is low; every ROM word is still issued exactly once.
